// File: rtl/reg_file_sb_if.sv
// Write/mark/read bundle for the reg_file_sb register file. The master side is the
// datapath/control, and the slave side is the register file.
interface reg_file_sb_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 3
);
  logic             Ld_Reg;
  logic [AW-1:0]    Dr;
  logic [WIDTH-1:0] D;
  logic [AW-1:0]    Sr1;
  logic [AW-1:0]    Sr2;
  logic [WIDTH-1:0] Sr1_Out;
  logic [WIDTH-1:0] Sr2_Out;
  logic             Mark;
  logic [AW-1:0]    Mark_Dr;
  logic             Busy_Sr1;
  logic             Busy_Sr2;
  logic             Busy_Any;
  logic             Addr_Err;

  modport master (
    output Ld_Reg, Dr, D, Sr1, Sr2, Mark, Mark_Dr,
    input  Sr1_Out, Sr2_Out, Busy_Sr1, Busy_Sr2, Busy_Any, Addr_Err
  );

  modport slave (
    input  Ld_Reg, Dr, D, Sr1, Sr2, Mark, Mark_Dr,
    output Sr1_Out, Sr2_Out, Busy_Sr1, Busy_Sr2, Busy_Any, Addr_Err
  );
endinterface

// File: rtl/reg_file_sb.sv
// LC-3 general-purpose register file: one synchronous write port, two combinational read
// ports, per-register busy scoreboard. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module reg_file_sb #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input logic          Clk,
  input logic          Reset,
  reg_file_sb_if.slave rf_bus
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic             addr_err_q, addr_err_d;

  // One-hot selects; an out-of-range address decodes to all zeros.
  logic [DEPTH-1:0] wr_sel, mark_sel, sr1_sel, sr2_sel;
  logic             dr_ok, mark_ok;

  always_comb begin
    wr_sel   = '0;
    mark_sel = '0;
    sr1_sel  = '0;
    sr2_sel  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      wr_sel[i]   = (32'(rf_bus.Dr) == i);
      mark_sel[i] = (32'(rf_bus.Mark_Dr) == i);
      sr1_sel[i]  = (32'(rf_bus.Sr1) == i);
      sr2_sel[i]  = (32'(rf_bus.Sr2) == i);
    end
  end

  assign dr_ok   = |wr_sel;
  assign mark_ok = |mark_sel;

  // Mark is applied after the write so a newer pending producer keeps the register busy.
  always_comb begin
    regs_d     = regs_q;
    busy_d     = busy_q;
    addr_err_d = addr_err_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rf_bus.Ld_Reg && wr_sel[i]) begin
        regs_d[i] = rf_bus.D;
        busy_d[i] = 1'b0;
      end
      if (rf_bus.Mark && mark_sel[i]) begin
        busy_d[i] = 1'b1;
      end
    end
    if ((rf_bus.Ld_Reg && !dr_ok) || (rf_bus.Mark && !mark_ok)) begin
      addr_err_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      regs_q     <= '{default: '0};
      busy_q     <= '0;
      addr_err_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      addr_err_q <= addr_err_d;
    end
  end

  logic [WIDTH-1:0] sr1_stored, sr2_stored;
  logic             busy1_stored, busy2_stored;

  always_comb begin
    sr1_stored = '0;
    sr2_stored = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sr1_sel[i]) sr1_stored = regs_q[i];
      if (sr2_sel[i]) sr2_stored = regs_q[i];
    end
  end

  assign busy1_stored = |(busy_q & sr1_sel);
  assign busy2_stored = |(busy_q & sr2_sel);

`ifdef REGFILE_BYPASS_EN
  logic fwd1, fwd2, mark_hit1, mark_hit2;

  assign fwd1      = rf_bus.Ld_Reg && dr_ok && (rf_bus.Sr1 == rf_bus.Dr);
  assign fwd2      = rf_bus.Ld_Reg && dr_ok && (rf_bus.Sr2 == rf_bus.Dr);
  assign mark_hit1 = rf_bus.Mark && mark_ok && (rf_bus.Sr1 == rf_bus.Mark_Dr);
  assign mark_hit2 = rf_bus.Mark && mark_ok && (rf_bus.Sr2 == rf_bus.Mark_Dr);

  assign rf_bus.Sr1_Out  = fwd1 ? rf_bus.D : sr1_stored;
  assign rf_bus.Sr2_Out  = fwd2 ? rf_bus.D : sr2_stored;
  assign rf_bus.Busy_Sr1 = fwd1 ? mark_hit1 : busy1_stored;
  assign rf_bus.Busy_Sr2 = fwd2 ? mark_hit2 : busy2_stored;
`else
  assign rf_bus.Sr1_Out  = sr1_stored;
  assign rf_bus.Sr2_Out  = sr2_stored;
  assign rf_bus.Busy_Sr1 = busy1_stored;
  assign rf_bus.Busy_Sr2 = busy2_stored;
`endif

  assign rf_bus.Busy_Any = |busy_q;
  assign rf_bus.Addr_Err = addr_err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a DEPTH=8 instance for the main function and a DEPTH=6
// instance for out-of-range addressing.
module tb_reg_file_sb;

  logic Clk;
  logic Reset;

  int n_checks;
  int n_fail;

  reg_file_sb_if #(.WIDTH(16), .AW(3)) bus_a ();
  reg_file_sb_if #(.WIDTH(16), .AW(3)) bus_b ();

  reg_file_sb #(.WIDTH(16), .DEPTH(8), .AW(3)) u_dut_a (
    .Clk    (Clk),
    .Reset  (Reset),
    .rf_bus (bus_a.slave)
  );

  reg_file_sb #(.WIDTH(16), .DEPTH(6), .AW(3)) u_dut_b (
    .Clk    (Clk),
    .Reset  (Reset),
    .rf_bus (bus_b.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Reset    = 1'b1;
    bus_a.Ld_Reg = 1'b0; bus_a.Dr = '0; bus_a.D = '0; bus_a.Sr1 = '0; bus_a.Sr2 = '0;
    bus_a.Mark   = 1'b0; bus_a.Mark_Dr = '0;
    bus_b.Ld_Reg = 1'b0; bus_b.Dr = '0; bus_b.D = '0; bus_b.Sr1 = '0; bus_b.Sr2 = '0;
    bus_b.Mark   = 1'b0; bus_b.Mark_Dr = '0;
    #12;
    Reset = 1'b0;
    #1;
    check_eq("rst_sr1_out", 32'(bus_a.Sr1_Out), 32'h0);
    check_eq("rst_busy_any", 32'(bus_a.Busy_Any), 32'h0);
    check_eq("rst_addr_err", 32'(bus_a.Addr_Err), 32'h0);

    // Load R3 and mark it busy in the same cycle, then reset asynchronously between edges.
    bus_a.Ld_Reg = 1'b1; bus_a.Dr = 3'd3; bus_a.D = 16'h1234;
    bus_a.Mark = 1'b1; bus_a.Mark_Dr = 3'd3;
    tick();
    bus_a.Ld_Reg = 1'b0; bus_a.Mark = 1'b0; bus_a.Sr1 = 3'd3;
    #1;
    check_eq("r3_loaded", 32'(bus_a.Sr1_Out), 32'h1234);
    check_eq("r3_busy", 32'(bus_a.Busy_Sr1), 32'h1);
    check_eq("r3_busy_any", 32'(bus_a.Busy_Any), 32'h1);
    Reset = 1'b1;
    #1;
    check_eq("async_rst_out", 32'(bus_a.Sr1_Out), 32'h0);
    check_eq("async_rst_busy", 32'(bus_a.Busy_Sr1), 32'h0);
    check_eq("async_rst_any", 32'(bus_a.Busy_Any), 32'h0);
    check_eq("async_rst_err", 32'(bus_a.Addr_Err), 32'h0);
    #1;
    Reset = 1'b0;

    // Write and dual read.
    bus_a.Ld_Reg = 1'b1; bus_a.Dr = 3'd2; bus_a.D = 16'hA5A5;
    tick();
    bus_a.Dr = 3'd7; bus_a.D = 16'h0F0F;
    tick();
    bus_a.Ld_Reg = 1'b0; bus_a.Sr1 = 3'd2; bus_a.Sr2 = 3'd7;
    #1;
    check_eq("rd_r2", 32'(bus_a.Sr1_Out), 32'hA5A5);
    check_eq("rd_r7", 32'(bus_a.Sr2_Out), 32'h0F0F);
    bus_a.Sr2 = 3'd2;
    #1;
    check_eq("same_sr1", 32'(bus_a.Sr1_Out), 32'hA5A5);
    check_eq("same_sr2", 32'(bus_a.Sr2_Out), 32'hA5A5);

    // Hold: Ld_Reg low must not change R2.
    bus_a.Dr = 3'd2; bus_a.D = 16'hFFFF;
    tick();
    check_eq("hold_r2", 32'(bus_a.Sr1_Out), 32'hA5A5);

    // Scoreboard mark then clearing write.
    bus_a.Mark = 1'b1; bus_a.Mark_Dr = 3'd5;
    tick();
    bus_a.Mark = 1'b0; bus_a.Sr1 = 3'd5;
    #1;
    check_eq("mark_r5_busy", 32'(bus_a.Busy_Sr1), 32'h1);
    check_eq("mark_r5_any", 32'(bus_a.Busy_Any), 32'h1);
    bus_a.Ld_Reg = 1'b1; bus_a.Dr = 3'd5; bus_a.D = 16'h0042;
    tick();
    bus_a.Ld_Reg = 1'b0;
    #1;
    check_eq("wr_r5_busy", 32'(bus_a.Busy_Sr1), 32'h0);
    check_eq("wr_r5_data", 32'(bus_a.Sr1_Out), 32'h0042);
    check_eq("wr_r5_any", 32'(bus_a.Busy_Any), 32'h0);

    // Write and mark on the same register: mark wins.
    bus_a.Ld_Reg = 1'b1; bus_a.Dr = 3'd1; bus_a.D = 16'h7777;
    bus_a.Mark = 1'b1; bus_a.Mark_Dr = 3'd1;
    tick();
    bus_a.Ld_Reg = 1'b0; bus_a.Mark = 1'b0; bus_a.Sr1 = 3'd1;
    #1;
    check_eq("wm_r1_data", 32'(bus_a.Sr1_Out), 32'h7777);
    check_eq("wm_r1_busy", 32'(bus_a.Busy_Sr1), 32'h1);

    // Mark R4, then write R4 while marking R6.
    bus_a.Mark = 1'b1; bus_a.Mark_Dr = 3'd4;
    tick();
    bus_a.Sr1 = 3'd4;
    #1;
    check_eq("mark_r4_busy", 32'(bus_a.Busy_Sr1), 32'h1);
    bus_a.Ld_Reg = 1'b1; bus_a.Dr = 3'd4; bus_a.D = 16'h4444; bus_a.Mark_Dr = 3'd6;
    tick();
    bus_a.Ld_Reg = 1'b0; bus_a.Mark = 1'b0; bus_a.Sr2 = 3'd6;
    #1;
    check_eq("split_r4_busy", 32'(bus_a.Busy_Sr1), 32'h0);
    check_eq("split_r4_data", 32'(bus_a.Sr1_Out), 32'h4444);
    check_eq("split_r6_busy", 32'(bus_a.Busy_Sr2), 32'h1);

    // Same-cycle read of a register being written (R6 holds 0 and is busy).
    bus_a.Ld_Reg = 1'b1; bus_a.Dr = 3'd6; bus_a.D = 16'hBEEF; bus_a.Sr1 = 3'd6;
    #1;
`ifdef REGFILE_BYPASS_EN
    check_eq("byp_same_data", 32'(bus_a.Sr1_Out), 32'hBEEF);
    check_eq("byp_same_busy", 32'(bus_a.Busy_Sr1), 32'h0);
`else
    check_eq("byp_same_data", 32'(bus_a.Sr1_Out), 32'h0000);
    check_eq("byp_same_busy", 32'(bus_a.Busy_Sr1), 32'h1);
`endif
    tick();
    bus_a.Ld_Reg = 1'b0;
    #1;
    check_eq("byp_next_data", 32'(bus_a.Sr1_Out), 32'hBEEF);
    check_eq("byp_next_busy", 32'(bus_a.Busy_Sr1), 32'h0);
    check_eq("r1_still_any", 32'(bus_a.Busy_Any), 32'h1);
    check_eq("a_no_addr_err", 32'(bus_a.Addr_Err), 32'h0);

    // Out-of-range handling on the DEPTH=6 instance.
    check_eq("b_err_clear", 32'(bus_b.Addr_Err), 32'h0);
    bus_b.Ld_Reg = 1'b1; bus_b.Dr = 3'd5; bus_b.D = 16'h5555;
    tick();
    bus_b.Dr = 3'd7; bus_b.D = 16'hDEAD;
    tick();
    bus_b.Ld_Reg = 1'b0;
    #1;
    check_eq("b_oor_wr_err", 32'(bus_b.Addr_Err), 32'h1);
    for (int i = 0; i < 6; i++) begin
      bus_b.Sr1 = 3'(i);
      #1;
      check_eq($sformatf("b_reg%0d", i), 32'(bus_b.Sr1_Out), (i == 5) ? 32'h5555 : 32'h0);
    end
    bus_b.Sr2 = 3'd6;
    #1;
    check_eq("b_oor_rd6", 32'(bus_b.Sr2_Out), 32'h0);
    check_eq("b_oor_busy6", 32'(bus_b.Busy_Sr2), 32'h0);
    bus_b.Mark = 1'b1; bus_b.Mark_Dr = 3'd6;
    tick();
    bus_b.Mark = 1'b0; bus_b.Sr1 = 3'd7;
    #1;
    check_eq("b_oor_mark_any", 32'(bus_b.Busy_Any), 32'h0);
    check_eq("b_oor_rd7", 32'(bus_b.Sr1_Out), 32'h0);
    tick();
    tick();
    tick();
    check_eq("b_err_sticky", 32'(bus_b.Addr_Err), 32'h1);
    Reset = 1'b1;
    #1;
    check_eq("b_err_rst", 32'(bus_b.Addr_Err), 32'h0);
    Reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
